// File: rtl/hyperbus_trans_sched.sv
// HyperBus transaction scheduler: arbitrates AXI AR/AW, issues one PHY command at a
// time, and blocks further grants until the transaction completes or the watchdog fires.
module hyperbus_trans_sched #(
    parameter int unsigned AxiAddrWidth  = 32,
    parameter int unsigned AxiDataWidth  = 64,
    parameter int unsigned LenWidth      = 8,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned AddrWidth    = $clog2(AxiDataWidth / 8)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    input  logic [AxiAddrWidth-1:0] ar_addr_i,
    input  logic [LenWidth-1:0]     ar_len_i,
    input  logic [2:0]              ar_size_i,

    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [AxiAddrWidth-1:0] aw_addr_i,
    input  logic [LenWidth-1:0]     aw_len_i,
    input  logic [2:0]              aw_size_i,

    output logic                    tx_valid_o,
    input  logic                    tx_ready_i,
    output logic                    tx_write_o,
    output logic [AxiAddrWidth-1:0] tx_addr_o,
    output logic [LenWidth-1:0]     tx_len_o,
    output logic [2:0]              tx_size_o,

    output logic                    trans_handshake_o,
    output logic                    is_a_read_o,
    output logic [AddrWidth-1:0]    start_addr_o,

    input  logic                    rd_done_i,
    input  logic                    wr_done_i,

    output logic                    busy_o,
    output logic                    timeout_o
);

    // state    | meaning
    // StIdle   | no transaction outstanding; AR/AW arbitration open
    // StIssue  | command presented to the PHY, waiting for tx_ready_i
    // StWait   | command accepted; waiting for done of the granted type or watchdog
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    localparam int unsigned     WdWidth = $clog2(TimeoutCycles);
    localparam logic [WdWidth-1:0] WdLast = WdWidth'(TimeoutCycles - 1);

    logic [1:0]              state_q;
    logic [1:0]              state_d;
    logic                    last_wr_q;
    logic                    cmd_write_q;
    logic [AxiAddrWidth-1:0] cmd_addr_q;
    logic [LenWidth-1:0]     cmd_len_q;
    logic [2:0]              cmd_size_q;
    logic [WdWidth-1:0]      wd_cnt_q;

    logic in_idle;
    logic in_issue;
    logic in_wait;
    logic grant_rd;
    logic grant_wr;
    logic txn_done;
    logic wd_expire;

    assign in_idle  = (state_q == StIdle);
    assign in_issue = (state_q == StIssue);
    assign in_wait  = (state_q == StWait);

    // On a tie the channel not granted last wins; last_wr_q resets to 1 so read wins first.
    assign grant_rd = in_idle && !rst_i && ar_valid_i && (!aw_valid_i || last_wr_q);
    assign grant_wr = in_idle && !rst_i && aw_valid_i && (!ar_valid_i || !last_wr_q);

    // Only the done of the granted type counts; the other one is ignored.
    assign txn_done  = in_wait && (cmd_write_q ? wr_done_i : rd_done_i);
    assign wd_expire = in_wait && (wd_cnt_q == WdLast);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (grant_rd || grant_wr) state_d = StIssue;
            StIssue: if (tx_ready_i)           state_d = StWait;
            StWait:  if (txn_done || wd_expire) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            last_wr_q   <= 1'b1;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
            cmd_size_q  <= '0;
            wd_cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            if (grant_rd || grant_wr) begin
                cmd_write_q <= grant_wr;
                cmd_addr_q  <= grant_wr ? aw_addr_i : ar_addr_i;
                cmd_len_q   <= grant_wr ? aw_len_i  : ar_len_i;
                cmd_size_q  <= grant_wr ? aw_size_i : ar_size_i;
                last_wr_q   <= grant_wr;
            end
            // Cleared while issuing so the count starts at zero on the first wait cycle.
            if (in_issue) begin
                wd_cnt_q <= '0;
            end else if (in_wait && (wd_cnt_q != WdLast)) begin
                wd_cnt_q <= wd_cnt_q + WdWidth'(1);
            end
        end
    end

    assign ar_ready_o        = grant_rd;
    assign aw_ready_o        = grant_wr;

    assign tx_valid_o        = in_issue;
    assign tx_write_o        = cmd_write_q;
    assign tx_addr_o         = cmd_addr_q;
    assign tx_len_o          = cmd_len_q;
    assign tx_size_o         = cmd_size_q;

    assign trans_handshake_o = in_issue && tx_ready_i && !rst_i;
    assign is_a_read_o       = ~cmd_write_q;
    assign start_addr_o      = cmd_addr_q[AddrWidth-1:0];

    assign busy_o            = !in_idle;
    // A reset cycle drops the transaction without reporting an abort.
    assign timeout_o         = wd_expire && !txn_done && !rst_i;

endmodule

// File: tb/tb_hyperbus_trans_sched.sv
// Directed bench for hyperbus_trans_sched; a scoreboard queue holds expected PHY
// commands and a negedge monitor checks each tx handshake against it.
module tb_hyperbus_trans_sched;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } cmd_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ar_valid_i, aw_valid_i;
    logic        ar_ready_o, aw_ready_o;
    logic [31:0] ar_addr_i, aw_addr_i;
    logic [7:0]  ar_len_i, aw_len_i;
    logic [2:0]  ar_size_i, aw_size_i;
    logic        tx_valid_o, tx_ready_i, tx_write_o;
    logic [31:0] tx_addr_o;
    logic [7:0]  tx_len_o;
    logic [2:0]  tx_size_o;
    logic        trans_handshake_o, is_a_read_o;
    logic [2:0]  start_addr_o;
    logic        rd_done_i, wr_done_i;
    logic        busy_o, timeout_o;

    int   errs   = 0;
    int   checks = 0;
    cmd_t sb_q[$];
    cmd_t exp_cmd;

    hyperbus_trans_sched #(
        .AxiAddrWidth (32),
        .AxiDataWidth (64),
        .LenWidth     (8),
        .TimeoutCycles(8)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ar_valid_i       (ar_valid_i),
        .ar_ready_o       (ar_ready_o),
        .ar_addr_i        (ar_addr_i),
        .ar_len_i         (ar_len_i),
        .ar_size_i        (ar_size_i),
        .aw_valid_i       (aw_valid_i),
        .aw_ready_o       (aw_ready_o),
        .aw_addr_i        (aw_addr_i),
        .aw_len_i         (aw_len_i),
        .aw_size_i        (aw_size_i),
        .tx_valid_o       (tx_valid_o),
        .tx_ready_i       (tx_ready_i),
        .tx_write_o       (tx_write_o),
        .tx_addr_o        (tx_addr_o),
        .tx_len_o         (tx_len_o),
        .tx_size_o        (tx_size_o),
        .trans_handshake_o(trans_handshake_o),
        .is_a_read_o      (is_a_read_o),
        .start_addr_o     (start_addr_o),
        .rd_done_i        (rd_done_i),
        .wr_done_i        (wr_done_i),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted PHY command must match the oldest expected one.
    always @(negedge clk_i) begin
        cmd_t c;
        if (!rst_i) begin
            chk("ready_exclusive", {63'd0, ar_ready_o & aw_ready_o}, 64'd0);
            if (tx_valid_o && tx_ready_i) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_cmd", 64'd1, 64'd0);
                end else begin
                    c = sb_q.pop_front();
                    chk("tx_write",   {63'd0, tx_write_o},        {63'd0, c.wr});
                    chk("tx_addr",    {32'd0, tx_addr_o},         {32'd0, c.addr});
                    chk("tx_len",     {56'd0, tx_len_o},          {56'd0, c.len});
                    chk("tx_size",    {61'd0, tx_size_o},         {61'd0, c.size});
                    chk("start_addr", {61'd0, start_addr_o},      {61'd0, c.addr[2:0]});
                    chk("is_a_read",  {63'd0, is_a_read_o},       {63'd0, ~c.wr});
                    chk("handshake",  {63'd0, trans_handshake_o}, 64'd1);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic set_ar(input logic v, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        ar_valid_i = v; ar_addr_i = a; ar_len_i = l; ar_size_i = s;
    endtask

    task automatic set_aw(input logic v, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        aw_valid_i = v; aw_addr_i = a; aw_len_i = l; aw_size_i = s;
    endtask

    // Idle cycle: check which channel is granted and record the expected command.
    task automatic grant_step(input bit exp_wr, input bit push);
        @(negedge clk_i);
        chk("grant_busy",     {63'd0, busy_o},     64'd0);
        chk("grant_ar_ready", {63'd0, ar_ready_o}, {63'd0, !exp_wr});
        chk("grant_aw_ready", {63'd0, aw_ready_o}, {63'd0, exp_wr});
        exp_cmd = exp_wr ? cmd_t'{1'b1, aw_addr_i, aw_len_i, aw_size_i}
                         : cmd_t'{1'b0, ar_addr_i, ar_len_i, ar_size_i};
        if (push) sb_q.push_back(exp_cmd);
        step();
    endtask

    // Issue phase: stall tx_ready_i for 'stall' cycles, then accept.
    task automatic handshake_step(input int stall);
        tx_ready_i = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk_i);
            chk("stall_tx_valid", {63'd0, tx_valid_o},        64'd1);
            chk("stall_tx_write", {63'd0, tx_write_o},        {63'd0, exp_cmd.wr});
            chk("stall_tx_addr",  {32'd0, tx_addr_o},         {32'd0, exp_cmd.addr});
            chk("stall_tx_len",   {56'd0, tx_len_o},          {56'd0, exp_cmd.len});
            chk("stall_tx_size",  {61'd0, tx_size_o},         {61'd0, exp_cmd.size});
            chk("stall_ar_ready", {63'd0, ar_ready_o},        64'd0);
            chk("stall_aw_ready", {63'd0, aw_ready_o},        64'd0);
            chk("stall_hs",       {63'd0, trans_handshake_o}, 64'd0);
            step();
        end
        tx_ready_i = 1'b1;
        @(negedge clk_i);
        chk("issue_tx_valid", {63'd0, tx_valid_o}, 64'd1);
        step();
        tx_ready_i = 1'b0;
    endtask

    task automatic complete(input bit wr);
        if (wr) wr_done_i = 1'b1; else rd_done_i = 1'b1;
        @(negedge clk_i);
        chk("done_busy",    {63'd0, busy_o},    64'd1);
        chk("done_timeout", {63'd0, timeout_o}, 64'd0);
        step();
        rd_done_i = 1'b0;
        wr_done_i = 1'b0;
    endtask

    initial begin
        set_ar(1'b0, 32'h0, 8'h0, 3'h0);
        set_aw(1'b0, 32'h0, 8'h0, 3'h0);
        tx_ready_i = 1'b0;
        rd_done_i  = 1'b0;
        wr_done_i  = 1'b0;
        do_reset();

        @(negedge clk_i);
        chk("rst_busy",     {63'd0, busy_o},            64'd0);
        chk("rst_tx_valid", {63'd0, tx_valid_o},        64'd0);
        chk("rst_ar_ready", {63'd0, ar_ready_o},        64'd0);
        chk("rst_aw_ready", {63'd0, aw_ready_o},        64'd0);
        chk("rst_timeout",  {63'd0, timeout_o},         64'd0);
        chk("rst_hs",       {63'd0, trans_handshake_o}, 64'd0);
        step();

        // T1: single read
        set_ar(1'b1, 32'h0000_1008, 8'd3, 3'd3);
        grant_step(1'b0, 1'b1);
        ar_valid_i = 1'b0;
        handshake_step(1);
        complete(1'b0);
        @(negedge clk_i);
        chk("t1_idle", {63'd0, busy_o}, 64'd0);
        step();

        // T2: simultaneous requests from reset alternate R,W,R,W
        do_reset();
        set_ar(1'b1, 32'h0000_2000, 8'd7, 3'd3);
        set_aw(1'b1, 32'h0000_3004, 8'd1, 3'd2);
        grant_step(1'b0, 1'b1); handshake_step(0); complete(1'b0);
        grant_step(1'b1, 1'b1); handshake_step(2); complete(1'b1);
        grant_step(1'b0, 1'b1); handshake_step(0); complete(1'b0);
        grant_step(1'b1, 1'b1); handshake_step(0);
        ar_valid_i = 1'b0;
        aw_valid_i = 1'b0;
        complete(1'b1);

        // T3: long PHY stall with a pending write request
        set_ar(1'b1, 32'h0000_0040, 8'd0, 3'd0);
        set_aw(1'b1, 32'h0000_0a0e, 8'd15, 3'd1);
        grant_step(1'b0, 1'b1);
        ar_valid_i = 1'b0;
        handshake_step(5);
        complete(1'b0);
        grant_step(1'b1, 1'b1);
        aw_valid_i = 1'b0;
        handshake_step(0);
        complete(1'b1);

        // T4: wrong-type done ignored; simultaneous dones complete the read once
        set_ar(1'b1, 32'h0000_1ff0, 8'd2, 3'd4);
        grant_step(1'b0, 1'b1);
        ar_valid_i = 1'b0;
        handshake_step(0);
        wr_done_i = 1'b1;
        @(negedge clk_i);
        chk("t4_wrdone_busy", {63'd0, busy_o}, 64'd1);
        step();
        wr_done_i = 1'b0;
        @(negedge clk_i);
        chk("t4_still_wait", {63'd0, busy_o}, 64'd1);
        step();
        rd_done_i = 1'b1;
        wr_done_i = 1'b1;
        @(negedge clk_i);
        chk("t4_both_busy", {63'd0, busy_o}, 64'd1);
        step();
        @(negedge clk_i);
        chk("t4_idle", {63'd0, busy_o}, 64'd1 - 64'd1);
        step();
        rd_done_i = 1'b0;
        wr_done_i = 1'b0;
        @(negedge clk_i);
        chk("t4_stay_idle", {63'd0, busy_o},     64'd0);
        chk("t4_no_valid",  {63'd0, tx_valid_o}, 64'd0);
        step();

        // T5: watchdog fires 8 cycles after the handshake
        set_ar(1'b1, 32'h0000_0100, 8'd1, 3'd3);
        grant_step(1'b0, 1'b1);
        ar_valid_i = 1'b0;
        handshake_step(0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            chk($sformatf("t5_timeout_c%0d", k), {63'd0, timeout_o}, {63'd0, k == 8});
            chk($sformatf("t5_busy_c%0d", k),    {63'd0, busy_o},    64'd1);
            step();
        end
        @(negedge clk_i);
        chk("t5_idle",       {63'd0, busy_o},    64'd0);
        chk("t5_pulse_once", {63'd0, timeout_o}, 64'd0);
        step();

        // T5b: done on the expiry cycle wins over the watchdog
        set_aw(1'b1, 32'h0000_0208, 8'd4, 3'd3);
        grant_step(1'b1, 1'b1);
        aw_valid_i = 1'b0;
        handshake_step(0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) wr_done_i = 1'b1;
            @(negedge clk_i);
            chk($sformatf("t5b_timeout_c%0d", k), {63'd0, timeout_o}, 64'd0);
            step();
            wr_done_i = 1'b0;
        end
        @(negedge clk_i);
        chk("t5b_idle", {63'd0, busy_o}, 64'd0);
        step();

        // T6: reset in WaitDone on the expiry cycle
        set_ar(1'b1, 32'h0000_0310, 8'd2, 3'd2);
        grant_step(1'b0, 1'b1);
        ar_valid_i = 1'b0;
        handshake_step(0);
        repeat (7) step();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t6_rst_no_timeout", {63'd0, timeout_o}, 64'd0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("t6_busy",       {63'd0, busy_o},            64'd0);
        chk("t6_tx_valid",   {63'd0, tx_valid_o},        64'd0);
        chk("t6_timeout",    {63'd0, timeout_o},         64'd0);
        chk("t6_hs",         {63'd0, trans_handshake_o}, 64'd0);
        chk("t6_tx_write",   {63'd0, tx_write_o},        64'd0);
        chk("t6_tx_addr",    {32'd0, tx_addr_o},         64'd0);
        chk("t6_tx_len",     {56'd0, tx_len_o},          64'd0);
        chk("t6_start_addr", {61'd0, start_addr_o},      64'd0);
        step();

        // T6b: reset in Issue while the PHY accepts; then a tie grants read
        set_aw(1'b1, 32'h0000_0400, 8'd0, 3'd3);
        grant_step(1'b1, 1'b0);
        aw_valid_i = 1'b0;
        tx_ready_i = 1'b1;
        rst_i      = 1'b1;
        @(negedge clk_i);
        chk("t6b_hs_masked", {63'd0, trans_handshake_o}, 64'd0);
        step();
        rst_i      = 1'b0;
        tx_ready_i = 1'b0;
        @(negedge clk_i);
        chk("t6b_busy",     {63'd0, busy_o},     64'd0);
        chk("t6b_tx_valid", {63'd0, tx_valid_o}, 64'd0);
        step();
        set_ar(1'b1, 32'h0000_0500, 8'd1, 3'd1);
        set_aw(1'b1, 32'h0000_0600, 8'd1, 3'd1);
        grant_step(1'b0, 1'b1);
        ar_valid_i = 1'b0;
        aw_valid_i = 1'b0;
        handshake_step(0);
        complete(1'b0);

        @(negedge clk_i);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
